lcd_driver: RTL and testbench



---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_if.sv | 21 ++
 rtl/lcd_timer.sv | 26 ++
 rtl/lcd_driver.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_driver.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 write sequencer.
// The LCD_INIT_EN macro adds the power-up and init states.
package lcd_pkg;

  localparam int LCD_BIT_ON = 31;
  localparam int LCD_BIT_GO = 10;
  localparam int LCD_BIT_RS = 9;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [0:3][7:0] INIT_CMDS = {8'h38, 8'h0C, 8'h01, 8'h06};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
`ifdef LCD_INIT_EN
    ST_WAIT,
    ST_PWRUP,
    ST_INIT
`else
    ST_WAIT
`endif
  } lcd_state_e;

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_if.sv
// LSU-side command word plus LCD bus and status signals of the sequencer.
interface lcd_if;
  logic [31:0] i_io_lcd;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_done_tgl;

  modport master (
    input  i_io_lcd,
    output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_done_tgl
  );

  modport slave (
    output i_io_lcd,
    input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_done_tgl
  );
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter with zero flag; a load of N gives N+1 cycles until zero is seen.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/lcd_driver.sv
// HD44780 write sequencer: one GO toggle -> one timed bus write (setup, EN, hold, exec wait).
// Build with LCD_INIT_EN to run the power-up wait and init command sequence after reset.
//
// state | meaning
// IDLE  | waiting for a GO toggle, EN low, not busy
// SETUP | RS/DATA stable before EN rises
// PULSE | EN high
// HOLD  | RS/DATA held after EN falls
// WAIT  | controller execution time (long for clear/home)
// PWRUP | power-on delay before init (LCD_INIT_EN)
// INIT  | latch next init command (LCD_INIT_EN)
module lcd_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_EN_HIGH    = 12,
  parameter int unsigned T_HOLD       = 1,
  parameter int unsigned T_EXEC       = 2000,
  parameter int unsigned T_CLEAR_EXEC = 82000,
  parameter int unsigned T_POWERUP    = 750000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  lcd_if.master bus
);

  localparam int unsigned T_MAX = max2(max2(max2(T_SETUP, T_EN_HIGH), max2(T_HOLD, T_EXEC)),
                                       max2(T_CLEAR_EXEC, T_POWERUP));
  localparam int TW = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_PULSE = TW'(T_EN_HIGH - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
  localparam logic [TW-1:0] LD_CLEAR = TW'(T_CLEAR_EXEC - 1);
`ifdef LCD_INIT_EN
  localparam logic [TW-1:0] LD_PWRUP = TW'(T_POWERUP - 1);
`endif

  lcd_state_e    state;
  logic          go_acc;
  logic [7:0]    data_q;
  logic          rs_q;
  logic          en_q;
  logic          on_q;
  logic          busy_q;
  logic          done_q;
  logic          start;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          unused_io;

`ifdef LCD_INIT_EN
  logic       init_done;
  logic       in_init;
  logic [1:0] init_idx;
  assign start = (state == ST_IDLE) && init_done && (bus.i_io_lcd[LCD_BIT_GO] != go_acc);
`else
  assign start = (state == ST_IDLE) && (bus.i_io_lcd[LCD_BIT_GO] != go_acc);
`endif

  assign unused_io = ^{bus.i_io_lcd[30:11], bus.i_io_lcd[8]};

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
`ifdef LCD_INIT_EN
        else if (!init_done) begin
          tmr_load = 1'b1;
          tmr_val  = LD_PWRUP;
        end
`endif
      end
      ST_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_PULSE;
      end
      ST_PULSE: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_HOLD;
      end
      ST_HOLD: begin
        tmr_load = tmr_zero;
        tmr_val  = is_slow_cmd(rs_q, data_q) ? LD_CLEAR : LD_EXEC;
      end
`ifdef LCD_INIT_EN
      ST_INIT: begin
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
`endif
      default: ;
    endcase
  end

  lcd_timer #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      go_acc <= 1'b0;
      data_q <= '0;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef LCD_INIT_EN
      init_done <= 1'b0;
      in_init   <= 1'b0;
      init_idx  <= '0;
`endif
    end else begin
      on_q <= bus.i_io_lcd[LCD_BIT_ON];
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_q <= bus.i_io_lcd[7:0];
            rs_q   <= bus.i_io_lcd[LCD_BIT_RS];
            go_acc <= bus.i_io_lcd[LCD_BIT_GO];
            busy_q <= 1'b1;
            state  <= ST_SETUP;
          end
`ifdef LCD_INIT_EN
          else if (!init_done) begin
            busy_q <= 1'b1;
            state  <= ST_PWRUP;
          end
`endif
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            en_q  <= 1'b1;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            en_q  <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_zero) begin
`ifdef LCD_INIT_EN
            if (in_init) begin
              if (init_idx == 2'd3) begin
                in_init   <= 1'b0;
                init_done <= 1'b1;
                busy_q    <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                state    <= ST_INIT;
              end
            end else begin
              busy_q <= 1'b0;
              done_q <= go_acc;
              state  <= ST_IDLE;
            end
`else
            busy_q <= 1'b0;
            done_q <= go_acc;
            state  <= ST_IDLE;
`endif
          end
        end
`ifdef LCD_INIT_EN
        ST_PWRUP: begin
          if (tmr_zero) begin
            in_init  <= 1'b1;
            init_idx <= '0;
            state    <= ST_INIT;
          end
        end
        // Init commands bypass go_acc so o_done_tgl only tracks software writes
        ST_INIT: begin
          data_q <= INIT_CMDS[init_idx];
          rs_q   <= 1'b0;
          state  <= ST_SETUP;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_lcd_data = data_q;
  assign bus.o_lcd_rs   = rs_q;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_en   = en_q;
  assign bus.o_lcd_on   = on_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done_tgl = done_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Bench for lcd_driver: directed scenarios plus random GO/data traffic against an elapsed-cycle model.
// With LCD_INIT_EN defined only the init-sequence scenario runs.
module tb_lcd_driver;

  localparam int TS = 2;
  localparam int TE = 4;
  localparam int TH = 1;
  localparam int TX = 10;
  localparam int TC = 30;
  localparam int TP = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  lcd_if bus ();

  lcd_driver #(
    .T_SETUP      (TS),
    .T_EN_HIGH    (TE),
    .T_HOLD       (TH),
    .T_EXEC       (TX),
    .T_CLEAR_EXEC (TC),
    .T_POWERUP    (TP)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] w);
    @(negedge clk);
    bus.i_io_lcd = w;
  endtask

  task automatic wait_busy(input logic val, input int lim, input string name);
    int n = 0;
    while (bus.o_busy !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.o_busy), 32'(val));
  endtask

  // Counts busy cycles from the current negedge, and where/how long EN was high within them
  task automatic measure(output int blen, output int elen, output int eoff);
    blen = 0;
    elen = 0;
    eoff = -1;
    while (bus.o_busy === 1'b1 && blen < 400) begin
      if (bus.o_lcd_en === 1'b1) begin
        if (eoff < 0) eoff = blen;
        elen++;
      end
      @(negedge clk);
      blen++;
    end
  endtask

  // Reference model: cycles elapsed since acceptance, outputs derived arithmetically
  int unsigned m_phase = 0;
  int unsigned m_len   = 0;
  logic        m_go    = 1'b0;
  logic        m_rs    = 1'b0;
  logic        m_on    = 1'b0;
  logic        m_done  = 1'b0;
  logic [7:0]  m_data  = 8'h00;

  function automatic int unsigned exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? TC : TX;
  endfunction

`ifndef LCD_INIT_EN
  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_go    = 1'b0;
      m_rs    = 1'b0;
      m_on    = 1'b0;
      m_done  = 1'b0;
      m_data  = 8'h00;
    end else begin
      m_on = bus.i_io_lcd[31];
      if (m_phase == 0) begin
        if (bus.i_io_lcd[10] != m_go) begin
          m_go    = bus.i_io_lcd[10];
          m_rs    = bus.i_io_lcd[9];
          m_data  = bus.i_io_lcd[7:0];
          m_len   = TS + TE + TH + exec_len(m_rs, m_data);
          m_phase = 1;
        end
      end else if (m_phase == m_len) begin
        m_phase = 0;
        m_done  = m_go;
      end else begin
        m_phase++;
      end
    end
    #1;
    check("m_busy", 32'(bus.o_busy), 32'(m_phase != 0));
    check("m_en", 32'(bus.o_lcd_en), 32'(m_phase > TS && m_phase <= TS + TE));
    check("m_data", 32'(bus.o_lcd_data), 32'(m_data));
    check("m_rs", 32'(bus.o_lcd_rs), 32'(m_rs));
    check("m_on", 32'(bus.o_lcd_on), 32'(m_on));
    check("m_done", 32'(bus.o_done_tgl), 32'(m_done));
    check("m_rw", 32'(bus.o_lcd_rw), 32'd0);
  end
`endif

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int blen, elen, eoff, n, rises;
    logic [31:0] w;
    logic prev_en;
`ifdef LCD_INIT_EN
    logic [7:0] seen[5];
    logic       seen_rs[5];
    logic       done_at5;
    logic [7:0] exp_init[4];
`endif
    bus.i_io_lcd = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

`ifdef LCD_INIT_EN
    exp_init[0] = 8'h38;
    exp_init[1] = 8'h0C;
    exp_init[2] = 8'h01;
    exp_init[3] = 8'h06;
    done_at5 = 1'b1;
    bus.i_io_lcd = 32'h0000_065A;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("init_busy_pwrup", 32'(bus.o_busy), 32'd1);
    n = 0;
    rises = 0;
    prev_en = 1'b0;
    while (rises < 5 && n < 3000) begin
      @(negedge clk);
      if (bus.o_lcd_en === 1'b1 && prev_en === 1'b0) begin
        seen[rises]    = bus.o_lcd_data;
        seen_rs[rises] = bus.o_lcd_rs;
        if (rises == 4) done_at5 = bus.o_done_tgl;
        rises++;
      end
      prev_en = bus.o_lcd_en;
      n++;
    end
    check("init_pulse_count", 32'(rises), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check("init_cmd_data", 32'(seen[i]), 32'(exp_init[i]));
      check("init_cmd_rs", 32'(seen_rs[i]), 32'd0);
    end
    check("user_after_init_data", 32'(seen[4]), 32'h5A);
    check("user_after_init_rs", 32'(seen_rs[4]), 32'd1);
    check("done_unchanged_by_init", 32'(done_at5), 32'd0);
    wait_busy(1'b0, 200, "user_txn_end");
    check("done_after_user", 32'(bus.o_done_tgl), 32'd1);
`else
    // 1: reset state and quiet bus
    check("reset_outputs", {24'h0, bus.o_lcd_data} | 32'({bus.o_lcd_rs, bus.o_lcd_rw,
          bus.o_lcd_en, bus.o_lcd_on, bus.o_busy, bus.o_done_tgl}), 32'd0);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.o_lcd_en === 1'b1 || bus.o_busy === 1'b1) rises++;
    end
    check("s1_quiet", 32'(rises), 32'd0);
    check("s1_done", 32'(bus.o_done_tgl), 32'd0);

    // 2: data write with ON
    drive(32'h8000_0641);
    @(negedge clk);
    check("s2_on", 32'(bus.o_lcd_on), 32'd1);
    check("s2_busy", 32'(bus.o_busy), 32'd1);
    check("s2_rs", 32'(bus.o_lcd_rs), 32'd1);
    check("s2_data", 32'(bus.o_lcd_data), 32'h41);
    measure(blen, elen, eoff);
    check("s2_busy_len", 32'(blen), 32'd17);
    check("s2_en_len", 32'(elen), 32'd4);
    check("s2_en_offset", 32'(eoff), 32'd2);
    check("s2_done", 32'(bus.o_done_tgl), 32'd1);

    // 3: clear command takes the long wait
    drive(32'h0000_0001);
    @(negedge clk);
    check("s3_data", 32'(bus.o_lcd_data), 32'h01);
    check("s3_rs", 32'(bus.o_lcd_rs), 32'd0);
    measure(blen, elen, eoff);
    check("s3_busy_len", 32'(blen), 32'd37);
    check("s3_en_len", 32'(elen), 32'd4);
    check("s3_done", 32'(bus.o_done_tgl), 32'd0);

    // 4: input changes while busy
    drive(32'h0000_0641);
    repeat (3) @(negedge clk);
    bus.i_io_lcd = 32'h0000_0655;
    repeat (2) @(negedge clk);
    check("s4_data_hold", 32'(bus.o_lcd_data), 32'h41);
    drive(32'h0000_0255);
    wait_busy(1'b0, 100, "s4_first_end");
    n = 0;
    while (bus.o_busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("s4_idle_gap", 32'(n), 32'd1);
    check("s4_second_data", 32'(bus.o_lcd_data), 32'h55);
    wait_busy(1'b0, 100, "s4_second_end");
    drive(32'h0000_0666);
    repeat (2) @(negedge clk);
    drive(32'h0000_0266);
    repeat (2) @(negedge clk);
    drive(32'h0000_0666);
    wait_busy(1'b0, 100, "s4_third_end");
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) rises++;
    end
    check("s4_double_flip_cancel", 32'(rises), 32'd0);

    // 5: reset during PULSE
    drive(32'h0000_0277);
    n = 0;
    while (bus.o_lcd_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("s5_en_reached", 32'(bus.o_lcd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_en_async", 32'(bus.o_lcd_en), 32'd0);
    check("s5_busy_async", 32'(bus.o_busy), 32'd0);
    bus.i_io_lcd = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.o_lcd_en === 1'b1 || bus.o_busy === 1'b1) rises++;
    end
    check("s5_no_resume", 32'(rises), 32'd0);

    // Random traffic: GO flips at random gaps, clear/home biased in, junk in ignored bits
    for (int i = 0; i < 80; i++) begin
      w = $urandom;
      w[10] = ($urandom_range(0, 1) == 1) ? ~bus.i_io_lcd[10] : bus.i_io_lcd[10];
      if ($urandom_range(0, 3) == 0) begin
        w[9]   = 1'b0;
        w[7:0] = 8'($urandom_range(1, 3));
      end
      drive(w);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (100) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
